// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register with valid/ready handshake, flush and bubble masking.
// Optional two-entry skid operation is enabled by defining ID_EX_SKID_EN.
module id_ex_pipe #(
  parameter int REG_LEN     = 32,
  parameter int RD_ADDR_LEN = 5,
  parameter int OP_CODE_LEN = 8,
  parameter int OP_SEL_LEN  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   id_valid,
  output logic                   id_ready,
  input  logic [REG_LEN-1:0]     id_pc,
  input  logic [REG_LEN-1:0]     id_reg1,
  input  logic [REG_LEN-1:0]     id_reg2,
  input  logic [REG_LEN-1:0]     id_imm,
  input  logic [RD_ADDR_LEN-1:0] id_rd,
  input  logic                   id_rd_enable,
  input  logic [OP_CODE_LEN-1:0] id_aluop,
  input  logic [OP_SEL_LEN-1:0]  id_alusel,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [REG_LEN-1:0]     ex_pc,
  output logic [REG_LEN-1:0]     ex_reg1,
  output logic [REG_LEN-1:0]     ex_reg2,
  output logic [REG_LEN-1:0]     ex_imm,
  output logic [RD_ADDR_LEN-1:0] ex_rd,
  output logic                   ex_rd_enable,
  output logic [OP_CODE_LEN-1:0] ex_aluop,
  output logic [OP_SEL_LEN-1:0]  ex_alusel
);

  // state | meaning
  // EMPTY | main register holds no beat
  // FULL  | main register valid, skid register empty
  // SKID  | main and skid registers both valid, input refused

  localparam int PAY_W = 4 * REG_LEN + RD_ADDR_LEN + 1 + OP_CODE_LEN + OP_SEL_LEN;

  logic [PAY_W-1:0] id_pay;
  logic [PAY_W-1:0] main_q;
  logic             valid_q;
  logic             main_rd_en;

  assign id_pay = {id_pc, id_reg1, id_reg2, id_imm, id_rd, id_rd_enable, id_aluop, id_alusel};

  assign {ex_pc, ex_reg1, ex_reg2, ex_imm, ex_rd, main_rd_en, ex_aluop, ex_alusel} = main_q;

  assign ex_valid     = valid_q;
  // a bubble must never write back, even though stale payload is held
  assign ex_rd_enable = main_rd_en & valid_q;

`ifdef ID_EX_SKID_EN

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [PAY_W-1:0] skid_q;
  logic             ready_q;
  logic             in_fire;
  logic             out_fire;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;

  assign id_ready = ready_q;
  assign in_fire  = id_valid & ready_q;
  assign out_fire = valid_q & ex_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d      = ST_FULL;
            load_main_in = 1'b1;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end else if (in_fire) begin
            state_d   = ST_SKID;
            load_skid = 1'b1;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            state_d        = ST_FULL;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // ready and valid are registered from the next state so neither is a decode of state_q
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d != ST_EMPTY);
      ready_q <= (state_d != ST_SKID);
      if (load_main_in) begin
        main_q <= id_pay;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= id_pay;
      end
    end
  end

`else

  logic in_fire;
  logic out_fire;

  assign id_ready = ~valid_q | ex_ready;
  assign in_fire  = id_valid & id_ready;
  assign out_fire = valid_q & ex_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      main_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_fire) begin
      valid_q <= 1'b1;
      main_q  <= id_pay;
    end else if (out_fire) begin
      valid_q <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: reset, streaming, stall, flush and bubble write-back.
module tb_id_ex_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc, id_reg1, id_reg2, id_imm;
  logic [4:0]  id_rd;
  logic        id_rd_enable;
  logic [7:0]  id_aluop;
  logic [2:0]  id_alusel;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc, ex_reg1, ex_reg2, ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_rd_enable;
  logic [7:0]  ex_aluop;
  logic [2:0]  ex_alusel;

  int checks;
  int errors;

  id_ex_pipe dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_reg1(id_reg1), .id_reg2(id_reg2), .id_imm(id_imm),
    .id_rd(id_rd), .id_rd_enable(id_rd_enable), .id_aluop(id_aluop), .id_alusel(id_alusel),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_rd_enable(ex_rd_enable), .ex_aluop(ex_aluop), .ex_alusel(ex_alusel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [31:0] pc, input logic rd_en);
    id_valid     = 1'b1;
    id_pc        = pc;
    id_reg1      = pc + 32'h1000;
    id_reg2      = ~pc;
    id_imm       = pc + 32'h7;
    id_rd        = 5'h1D;
    id_rd_enable = rd_en;
    id_aluop     = 8'hA5;
    id_alusel    = 3'h6;
  endtask

  task automatic do_reset();
    rst = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b0;
    id_pc = '0; id_reg1 = '0; id_reg2 = '0; id_imm = '0;
    id_rd = '0; id_rd_enable = 1'b0; id_aluop = '0; id_alusel = '0;
    repeat (2) cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ex_valid !== 1'b0 || id_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: ex_valid=%b id_ready=%b required 0/1", ex_valid, id_ready);
    end
    checks++;
    if ({ex_pc, ex_reg1, ex_reg2, ex_imm, ex_rd, ex_rd_enable, ex_aluop, ex_alusel} !== '0) begin
      errors++;
      $display("FAIL reset_payload: ex_pc=%h ex_reg1=%h required all zero", ex_pc, ex_reg1);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive_beat(32'h100, 1'b1);
    ex_ready = 1'b0;
    cyc();
    id_valid = 1'b0;
    cyc();
    checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h100 || ex_rd_enable !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold: ex_valid=%b ex_pc=%h ex_rd_enable=%b required 1/00000100/1",
               ex_valid, ex_pc, ex_rd_enable);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ex_valid !== 1'b0 || id_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_flags: ex_valid=%b id_ready=%b required 0/1", ex_valid, id_ready);
    end
    checks++;
    if ({ex_pc, ex_reg1, ex_reg2, ex_imm, ex_rd, ex_rd_enable, ex_aluop, ex_alusel} !== '0) begin
      errors++;
      $display("FAIL async_reset_payload: ex_pc=%h ex_imm=%h ex_aluop=%h required zero",
               ex_pc, ex_imm, ex_aluop);
    end
    #2 rst = 1'b1;
    cyc();
    checks++;
    if (ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_valid: ex_valid=%b required 0", ex_valid);
    end
  endtask

  task automatic test_streaming();
    do_reset();
    ex_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_beat(32'(i * 4), (i % 2) == 1);
      #1;
      checks++;
      if (id_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready[%0d]: id_ready=%b required 1", i, id_ready);
      end
      cyc();
      checks++;
      if (ex_valid !== 1'b1 || ex_pc !== 32'(i * 4) || ex_reg1 !== 32'(i * 4 + 32'h1000) ||
          ex_rd_enable !== ((i % 2) == 1) || ex_imm !== 32'(i * 4 + 7)) begin
        errors++;
        $display("FAIL stream_beat[%0d]: valid=%b pc=%h reg1=%h imm=%h rd_en=%b required 1/%h/%h/%h/%0d",
                 i, ex_valid, ex_pc, ex_reg1, ex_imm, ex_rd_enable,
                 32'(i * 4), 32'(i * 4 + 32'h1000), 32'(i * 4 + 7), i % 2);
      end
    end
    id_valid = 1'b0;
    cyc();
    checks++;
    if (ex_valid !== 1'b0 || ex_rd_enable !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: ex_valid=%b ex_rd_enable=%b required 0/0", ex_valid, ex_rd_enable);
    end
  endtask

`ifdef ID_EX_SKID_EN
  task automatic test_stall_skid();
    do_reset();
    ex_ready = 1'b0;
    drive_beat(32'h40, 1'b1);
    cyc();
    checks++;
    if (ex_pc !== 32'h40 || ex_valid !== 1'b1 || id_ready !== 1'b1) begin
      errors++;
      $display("FAIL skid_a: pc=%h valid=%b id_ready=%b required 00000040/1/1", ex_pc, ex_valid, id_ready);
    end
    drive_beat(32'h44, 1'b0);
    cyc();
    checks++;
    if (ex_pc !== 32'h40 || id_ready !== 1'b0) begin
      errors++;
      $display("FAIL skid_b: pc=%h id_ready=%b required 00000040/0", ex_pc, id_ready);
    end
    drive_beat(32'h48, 1'b0);
    cyc();
    checks++;
    if (ex_pc !== 32'h40 || id_ready !== 1'b0 || ex_rd_enable !== 1'b1) begin
      errors++;
      $display("FAIL skid_refuse: pc=%h id_ready=%b rd_en=%b required 00000040/0/1",
               ex_pc, id_ready, ex_rd_enable);
    end
    id_valid = 1'b0;
    ex_ready = 1'b1;
    cyc();
    checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h44 || ex_rd_enable !== 1'b0 || id_ready !== 1'b1) begin
      errors++;
      $display("FAIL skid_release: valid=%b pc=%h rd_en=%b id_ready=%b required 1/00000044/0/1",
               ex_valid, ex_pc, ex_rd_enable, id_ready);
    end
    cyc();
    checks++;
    if (ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL skid_drain: valid=%b pc=%h required valid 0", ex_valid, ex_pc);
    end
  endtask

  task automatic test_flush_skid();
    do_reset();
    ex_ready = 1'b0;
    drive_beat(32'h70, 1'b1);
    cyc();
    drive_beat(32'h74, 1'b1);
    cyc();
    checks++;
    if (id_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_skid_setup: id_ready=%b required 0", id_ready);
    end
    drive_beat(32'h80, 1'b1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    id_valid = 1'b0;
    checks++;
    if (ex_valid !== 1'b0 || ex_rd_enable !== 1'b0 || id_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_skid: valid=%b rd_en=%b id_ready=%b required 0/0/1",
               ex_valid, ex_rd_enable, id_ready);
    end
    ex_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (ex_valid !== 1'b0 || ex_pc === 32'h80) begin
        errors++;
        $display("FAIL flush_skid_after[%0d]: valid=%b pc=%h required valid 0, pc not 00000080",
                 i, ex_valid, ex_pc);
      end
    end
  endtask
`else
  task automatic test_no_skid();
    do_reset();
    ex_ready = 1'b0;
    drive_beat(32'h60, 1'b0);
    cyc();
    id_valid = 1'b0;
    #1;
    checks++;
    if (ex_valid !== 1'b1 || id_ready !== 1'b0) begin
      errors++;
      $display("FAIL noskid_stall_ready: valid=%b id_ready=%b required 1/0", ex_valid, id_ready);
    end
    ex_ready = 1'b1;
    #1;
    checks++;
    if (id_ready !== 1'b1) begin
      errors++;
      $display("FAIL noskid_comb_ready: id_ready=%b required 1", id_ready);
    end
    ex_ready = 1'b0;
    drive_beat(32'h64, 1'b1);
    cyc();
    checks++;
    if (ex_pc !== 32'h60 || ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL noskid_refuse: pc=%h valid=%b required 00000060/1", ex_pc, ex_valid);
    end
    ex_ready = 1'b1;
    cyc();
    id_valid = 1'b0;
    checks++;
    if (ex_pc !== 32'h64 || ex_valid !== 1'b1 || ex_rd_enable !== 1'b1) begin
      errors++;
      $display("FAIL noskid_advance: pc=%h valid=%b rd_en=%b required 00000064/1/1",
               ex_pc, ex_valid, ex_rd_enable);
    end
    cyc();
    checks++;
    if (ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL noskid_drain: valid=%b required 0", ex_valid);
    end
  endtask
`endif

  task automatic test_flush_full();
    do_reset();
    ex_ready = 1'b1;
    drive_beat(32'h90, 1'b1);
    cyc();
    checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h90) begin
      errors++;
      $display("FAIL flush_full_setup: valid=%b pc=%h required 1/00000090", ex_valid, ex_pc);
    end
    drive_beat(32'h80, 1'b1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    id_valid = 1'b0;
    checks++;
    if (ex_valid !== 1'b0 || ex_rd_enable !== 1'b0 || id_ready !== 1'b1 || ex_pc === 32'h80) begin
      errors++;
      $display("FAIL flush_full: valid=%b rd_en=%b id_ready=%b pc=%h required 0/0/1, pc not 00000080",
               ex_valid, ex_rd_enable, id_ready, ex_pc);
    end
    cyc();
    checks++;
    if (ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_full_after: valid=%b pc=%h required valid 0", ex_valid, ex_pc);
    end
  endtask

  task automatic test_bubble();
    do_reset();
    ex_ready = 1'b1;
    drive_beat(32'hC0, 1'b1);
    id_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (ex_valid !== 1'b0 || ex_rd_enable !== 1'b0) begin
        errors++;
        $display("FAIL bubble[%0d]: valid=%b rd_en=%b required 0/0", i, ex_valid, ex_rd_enable);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_reset_mid_stall();
    test_streaming();
`ifdef ID_EX_SKID_EN
    test_stall_skid();
    test_flush_skid();
`else
    test_no_skid();
`endif
    test_flush_full();
    test_bubble();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
